// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream/decrypt stage and the key-search logic around it.
package rc4_pkg;

  localparam int MSG_LEN_DEF = 32;

  localparam logic [7:0] CHAR_LO = 8'h61;
  localparam logic [7:0] CHAR_HI = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RD_I  = 4'd1,
    ST_WT_I  = 4'd2,
    ST_CAP_I = 4'd3,
    ST_RD_J  = 4'd4,
    ST_WT_J  = 4'd5,
    ST_CAP_J = 4'd6,
    ST_WR_I  = 4'd7,
    ST_WR_J  = 4'd8,
    ST_RD_F  = 4'd9,
    ST_WT_F  = 4'd10,
    ST_CAP_F = 4'd11,
    ST_WR_D  = 4'd12,
    ST_NEXT  = 4'd13,
    ST_DONE  = 4'd14
  } rc4_state_e;

endpackage

// File: rtl/rc4_char_check.sv
// Plaintext byte filter: lowercase ASCII letter or space counts as plausible text.
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] ch,
  output logic       valid
);

  always_comb begin
    valid = ((ch >= CHAR_LO) && (ch <= CHAR_HI)) || (ch == CHAR_SP);
  end

endmodule

// File: rtl/rc4_prga.sv
// RC4 PRGA: walks the permuted S memory, XORs the keystream with the encrypted ROM,
// writes plaintext to RAM and aborts early on the first non-text byte.
module rc4_prga
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter int MSG_AW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              key_ok,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] enc_addr,
  input  logic [7:0]        enc_q,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_data,
  output logic              dec_wren
);

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  rc4_state_e        state;
  logic [7:0]        i;
  logic [7:0]        j;
  logic [MSG_AW-1:0] k;
  logic [7:0]        si;
  logic [7:0]        sj;
  logic              bad;
  logic              byte_ok;

  rc4_char_check u_char_check (
    .ch    (dec_data),
    .valid (byte_ok)
  );

  // Swap operands are pure data: captured in CAP_I / CAP_J, never reset.
  always_ff @(posedge clk) begin
    if (state == ST_CAP_I) si <= s_q;
    if (state == ST_CAP_J) sj <= s_q;
  end

  // Outputs are loaded on the edge that enters the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      bad      <= 1'b0;
      done     <= 1'b0;
      key_ok   <= 1'b0;
      s_addr   <= '0;
      s_data   <= '0;
      s_wren   <= 1'b0;
      enc_addr <= '0;
      dec_addr <= '0;
      dec_data <= '0;
      dec_wren <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            i      <= 8'd1;
            j      <= '0;
            k      <= '0;
            bad    <= 1'b0;
            key_ok <= 1'b0;
            s_addr <= 8'd1;
            state  <= ST_RD_I;
          end
        end
        ST_RD_I:  state <= ST_WT_I;
        ST_WT_I:  state <= ST_CAP_I;
        ST_CAP_I: begin
          j      <= j + s_q;
          s_addr <= j + s_q;
          state  <= ST_RD_J;
        end
        ST_RD_J:  state <= ST_WT_J;
        ST_WT_J:  state <= ST_CAP_J;
        ST_CAP_J: begin
          s_addr <= i;
          s_data <= s_q;
          s_wren <= 1'b1;
          state  <= ST_WR_I;
        end
        ST_WR_I: begin
          s_addr <= j;
          s_data <= si;
          state  <= ST_WR_J;
        end
        ST_WR_J: begin
          s_wren   <= 1'b0;
          s_addr   <= si + sj;
          enc_addr <= k;
          state    <= ST_RD_F;
        end
        ST_RD_F:  state <= ST_WT_F;
        ST_WT_F:  state <= ST_CAP_F;
        ST_CAP_F: begin
          // f and the cipher byte are only ever needed as their XOR, so that is what is kept.
          dec_addr <= k;
          dec_data <= s_q ^ enc_q;
          dec_wren <= 1'b1;
          state    <= ST_WR_D;
        end
        ST_WR_D: begin
          dec_wren <= 1'b0;
          bad      <= ~byte_ok;
          state    <= ST_NEXT;
        end
        ST_NEXT: begin
          k <= k + 1'b1;
          if ((k == K_LAST) || bad) begin
            done   <= 1'b1;
            key_ok <= ~bad;
            state  <= ST_DONE;
          end else begin
            i      <= i + 8'd1;
            s_addr <= i + 8'd1;
            state  <= ST_RD_I;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga.sv
// Bench for rc4_prga: three instances (MSG_LEN 4, 1, 32) with behavioural memories
// and an RC4 reference model for randomized permutations.
module tb_rc4_prga;

  logic       clk;
  logic       reset;
  logic [2:0] start_v;
  logic [2:0] ld;

  logic       done_a, key_ok_a, s_wren_a, dec_wren_a;
  logic [7:0] s_addr_a, s_data_a, s_q_a, enc_q_a, dec_data_a;
  logic [1:0] enc_addr_a, dec_addr_a;

  logic       done_b, key_ok_b, s_wren_b, dec_wren_b;
  logic [7:0] s_addr_b, s_data_b, s_q_b, enc_q_b, dec_data_b;
  logic [0:0] enc_addr_b, dec_addr_b;

  logic       done_c, key_ok_c, s_wren_c, dec_wren_c;
  logic [7:0] s_addr_c, s_data_c, s_q_c, enc_q_c, dec_data_c;
  logic [4:0] enc_addr_c, dec_addr_c;

  logic [7:0] s_a [256];
  logic [7:0] s_b [256];
  logic [7:0] s_c [256];
  logic [7:0] enc_a [32];
  logic [7:0] enc_b [32];
  logic [7:0] enc_c [32];
  logic [7:0] dec_a [32];
  logic [7:0] dec_b [32];
  logic [7:0] dec_c [32];
  logic [7:0] s_init [256];
  logic [7:0] enc_init [32];

  logic [15:0] obs_sw [$];
  logic [15:0] obs_dw [$];
  logic [15:0] exp_sw [$];
  logic [15:0] exp_dw [$];
  logic [7:0]  m_s [256];
  logic [7:0]  ks [32];
  bit          m_ok;

  logic [2:0] done_v, dwren_v, kok_v;
  assign done_v  = {done_c, done_b, done_a};
  assign dwren_v = {dec_wren_c, dec_wren_b, dec_wren_a};
  assign kok_v   = {key_ok_c, key_ok_b, key_ok_a};

  int n_checks;
  int n_fail;

  rc4_prga #(.MSG_LEN(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .done(done_a), .key_ok(key_ok_a),
    .s_addr(s_addr_a), .s_data(s_data_a), .s_wren(s_wren_a), .s_q(s_q_a),
    .enc_addr(enc_addr_a), .enc_q(enc_q_a),
    .dec_addr(dec_addr_a), .dec_data(dec_data_a), .dec_wren(dec_wren_a)
  );

  rc4_prga #(.MSG_LEN(1)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .done(done_b), .key_ok(key_ok_b),
    .s_addr(s_addr_b), .s_data(s_data_b), .s_wren(s_wren_b), .s_q(s_q_b),
    .enc_addr(enc_addr_b), .enc_q(enc_q_b),
    .dec_addr(dec_addr_b), .dec_data(dec_data_b), .dec_wren(dec_wren_b)
  );

  rc4_prga #(.MSG_LEN(32)) u_dut_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .done(done_c), .key_ok(key_ok_c),
    .s_addr(s_addr_c), .s_data(s_data_c), .s_wren(s_wren_c), .s_q(s_q_c),
    .enc_addr(enc_addr_c), .enc_q(enc_q_c),
    .dec_addr(dec_addr_c), .dec_data(dec_data_c), .dec_wren(dec_wren_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous one-cycle-latency memories; ld copies the init images in.
  always @(posedge clk) begin
    if (ld[0]) begin
      s_a <= s_init; enc_a <= enc_init;
    end else if (s_wren_a) s_a[s_addr_a] <= s_data_a;
    s_q_a   <= s_a[s_addr_a];
    enc_q_a <= enc_a[enc_addr_a];
    if (dec_wren_a) dec_a[dec_addr_a] <= dec_data_a;
  end

  always @(posedge clk) begin
    if (ld[1]) begin
      s_b <= s_init; enc_b <= enc_init;
    end else if (s_wren_b) s_b[s_addr_b] <= s_data_b;
    s_q_b   <= s_b[s_addr_b];
    enc_q_b <= enc_b[enc_addr_b];
    if (dec_wren_b) dec_b[dec_addr_b] <= dec_data_b;
  end

  always @(posedge clk) begin
    if (ld[2]) begin
      s_c <= s_init; enc_c <= enc_init;
    end else if (s_wren_c) begin
      s_c[s_addr_c] <= s_data_c;
      obs_sw.push_back({s_addr_c, s_data_c});
    end
    s_q_c   <= s_c[s_addr_c];
    enc_q_c <= enc_c[enc_addr_c];
    if (dec_wren_c) begin
      dec_c[dec_addr_c] <= dec_data_c;
      obs_dw.push_back({3'b000, dec_addr_c, dec_data_c});
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_text(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7a)) || (c == 8'h20);
  endfunction

  // Plain RC4 over the init image; with use_enc it also forms plaintext and stops at the first non-text byte.
  task automatic model_run(input int len, input bit use_enc);
    int ii, jj;
    logic [7:0] a, b, f, p;
    for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
    exp_sw.delete();
    exp_dw.delete();
    m_ok = 1'b1;
    ii = 0;
    jj = 0;
    for (int kk = 0; kk < len; kk++) begin
      ii = (ii + 1) % 256;
      a  = m_s[ii];
      jj = (jj + a) % 256;
      b  = m_s[jj];
      m_s[ii] = b;
      m_s[jj] = a;
      exp_sw.push_back({8'(ii), b});
      exp_sw.push_back({8'(jj), a});
      f = m_s[(a + b) % 256];
      ks[kk] = f;
      if (use_enc) begin
        p = f ^ enc_init[kk];
        exp_dw.push_back({8'(kk), p});
        if (!is_text(p)) begin
          m_ok = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic load(input int u);
    @(negedge clk);
    ld[u] = 1'b1;
    @(negedge clk);
    ld[u] = 1'b0;
  endtask

  // Starts unit u and watches it for a fixed window; optional extra start pulse after edge pulse_at.
  task automatic run(input int u, input int budget, input int pulse_at,
                     output int dcyc, output int ndone, output int nwr, output logic kok);
    dcyc  = -1;
    ndone = 0;
    nwr   = 0;
    kok   = 1'bx;
    @(negedge clk);
    start_v[u] = 1'b1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) start_v[u] = 1'b0;
      if (n == pulse_at) start_v[u] = 1'b1;
      if (n == pulse_at + 1) start_v[u] = 1'b0;
      if (done_v[u]) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = n;
          kok  = kok_v[u];
        end
      end
      if (dwren_v[u]) nwr++;
    end
    if (dcyc < 0) check_val("done_timeout", 32'(budget), 32'hFFFF_FFFF);
  endtask

  task automatic setup_abcd();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int x = 0; x < 32; x++) enc_init[x] = 8'h00;
    enc_init[0] = 8'h63;
    enc_init[1] = 8'h67;
    enc_init[2] = 8'h64;
    enc_init[3] = 8'h69;
  endtask

  task automatic check_abcd(input string pfx, input int dc, input int nd, input int nw, input logic ko);
    logic [7:0] want [4];
    want = '{8'h61, 8'h62, 8'h63, 8'h64};
    check_val({pfx, "_done_cyc"}, dc, 53);
    check_val({pfx, "_done_cnt"}, nd, 1);
    check_val({pfx, "_dec_wren_cnt"}, nw, 4);
    check_val({pfx, "_key_ok"}, ko, 1'b1);
    check_val({pfx, "_key_ok_held"}, key_ok_a, 1'b1);
    for (int x = 0; x < 4; x++) check_val($sformatf("%s_dec%0d", pfx, x), dec_a[x], want[x]);
  endtask

  initial begin
    int dc, nd, nw, bad_at, diffs, base_s, base_d, nb;
    logic ko;
    logic [7:0] t;
    int r;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start_v  = '0;
    ld       = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outs_a", {s_addr_a, s_data_a, s_wren_a, enc_addr_a, dec_addr_a,
                             dec_data_a, dec_wren_a, done_a, key_ok_a}, 32'h0);
    check_val("rst_outs_b", {s_addr_b, s_data_b, s_wren_b, enc_addr_b, dec_addr_b,
                             dec_data_b, dec_wren_b, done_b, key_ok_b}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // identity S, "abcd"
    setup_abcd();
    load(0);
    run(0, 13 * 4 + 12, 0, dc, nd, nw, ko);
    check_abcd("sc1", dc, nd, nw, ko);

    // identity S, all-zero cipher: first byte 02 is written, then abort
    for (int x = 0; x < 32; x++) enc_init[x] = 8'h00;
    load(0);
    run(0, 30, 0, dc, nd, nw, ko);
    check_val("sc2_done_cyc", dc, 14);
    check_val("sc2_done_cnt", nd, 1);
    check_val("sc2_dec_wren_cnt", nw, 1);
    check_val("sc2_key_ok", ko, 1'b0);
    check_val("sc2_dec0", dec_a[0], 8'h02);

    // reversed S, single byte, f index wraps to FF
    for (int x = 0; x < 256; x++) s_init[x] = 8'(255 - x);
    enc_init[0] = 8'h61;
    load(1);
    run(1, 30, 0, dc, nd, nw, ko);
    check_val("sc3_done_cyc", dc, 14);
    check_val("sc3_done_cnt", nd, 1);
    check_val("sc3_key_ok", ko, 1'b1);
    check_val("sc3_dec0", dec_b[0], 8'h61);
    check_val("sc3_s1", s_b[1], 8'h01);
    check_val("sc3_sfe", s_b[254], 8'hFE);

    // start pulsed mid-run is ignored
    setup_abcd();
    load(0);
    run(0, 13 * 4 + 20, 20, dc, nd, nw, ko);
    check_abcd("sc4", dc, nd, nw, ko);

    // reset while in WR_I
    setup_abcd();
    load(0);
    @(negedge clk);
    start_v[0] = 1'b1;
    repeat (7) begin
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
    end
    check_val("sc5_wr_i_wren", s_wren_a, 1'b1);
    check_val("sc5_wr_i_addr", s_addr_a, 8'h01);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("sc5_rst_outs", {s_addr_a, s_data_a, s_wren_a, enc_addr_a, dec_addr_a,
                               dec_data_a, dec_wren_a, done_a, key_ok_a}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    setup_abcd();
    load(0);
    run(0, 13 * 4 + 12, 0, dc, nd, nw, ko);
    check_abcd("sc5", dc, nd, nw, ko);

    // random permutations, MSG_LEN=32: one full run, one aborted at a random byte
    for (int it = 0; it < 2; it++) begin
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
      for (int x = 255; x > 0; x--) begin
        r = $urandom_range(x, 0);
        t = s_init[x];
        s_init[x] = s_init[r];
        s_init[r] = t;
      end
      model_run(32, 1'b0);
      bad_at = (it == 0) ? -1 : int'($urandom_range(31, 0));
      for (int x = 0; x < 32; x++) begin
        r = $urandom_range(26, 0);
        enc_init[x] = ks[x] ^ ((r == 26) ? 8'h20 : 8'(8'h61 + r));
        if (x == bad_at) enc_init[x] = ks[x] ^ 8'h80;
      end
      model_run(32, 1'b1);
      base_s = obs_sw.size();
      base_d = obs_dw.size();
      load(2);
      run(2, 13 * 32 + 12, 0, dc, nd, nw, ko);
      nb = exp_dw.size();
      check_val($sformatf("rnd%0d_done_cyc", it), dc, 13 * nb + 1);
      check_val($sformatf("rnd%0d_done_cnt", it), nd, 1);
      check_val($sformatf("rnd%0d_key_ok", it), ko, m_ok);
      check_val($sformatf("rnd%0d_s_wr_cnt", it), obs_sw.size() - base_s, exp_sw.size());
      check_val($sformatf("rnd%0d_dec_wr_cnt", it), obs_dw.size() - base_d, nb);
      for (int e = 0; e < exp_sw.size(); e++)
        check_val($sformatf("rnd%0d_s_wr%0d", it, e),
                  (base_s + e < obs_sw.size()) ? 32'(obs_sw[base_s + e]) : 32'hDEAD0000,
                  32'(exp_sw[e]));
      for (int e = 0; e < nb; e++)
        check_val($sformatf("rnd%0d_dec_wr%0d", it, e),
                  (base_d + e < obs_dw.size()) ? 32'(obs_dw[base_d + e]) : 32'hDEAD0000,
                  32'(exp_dw[e]));
      diffs = 0;
      for (int x = 0; x < 256; x++) if (s_c[x] !== m_s[x]) diffs++;
      check_val($sformatf("rnd%0d_s_final_diffs", it), diffs, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
